// File: rtl/tanh_arb_pkg.sv
// Shared types and constants for the tanh engine arbiter.
package tanh_arb_pkg;

  localparam int STATE_W     = 3;
  localparam int TMO_DEFAULT = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DELIVER   = 3'd4,
    DRAIN     = 3'd5
  } state_t;

endpackage

// File: rtl/tanh_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at ptr, ptr+1, ... with wrap.
module rr_pick
  import tanh_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int unsigned sum;
    logic [IW-1:0] cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      sum = int'(ptr) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IW'(sum);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tanh_arbiter.sv
// Round-robin arbiter/sequencer sharing one tanh series engine among NREQ requesters,
// with a per-run watchdog that aborts a stuck engine and drains it before the next grant.
module tanh_arbiter
  import tanh_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int TMO  = TMO_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] x_in,
  output logic [NREQ-1:0] grant,
  output logic            done,
  output logic            err,
  output logic [W-1:0]    y_out,
  output logic            eng_start,
  output logic [W-1:0]    eng_x,
  input  logic            eng_ready,
  input  logic [W-1:0]    eng_y,
  output logic            busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int WDW = $clog2(TMO) + 1;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic [W-1:0]    pick_x;
  logic [WDW-1:0]  wd;
  logic            wd_expired;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    pick_x = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_x = x_in[i*W +: W];
    end
  end

  assign wd_expired = (wd == WDW'(TMO - 1));
  assign next_ptr   = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
  assign busy       = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      y_out     <= '0;
      eng_start <= 1'b0;
      eng_x     <= '0;
      ptr       <= '0;
      winner    <= '0;
      wd        <= '0;
    end else begin
      done      <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req && eng_ready) begin
            grant  <= pick_gnt;
            winner <= pick_idx;
            eng_x  <= pick_x;
            wd     <= '0;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          eng_start <= 1'b1;
          state     <= WAIT_ACK;
        end
        WAIT_ACK, WAIT_DONE: begin
          // Watchdog wins over a same-cycle ready so an aborted run never reports success.
          if (wd_expired) begin
            done  <= 1'b1;
            err   <= 1'b1;
            y_out <= '0;
            ptr   <= next_ptr;
            grant <= '0;
            state <= DRAIN;
          end else begin
            wd <= wd + WDW'(1);
            if (state == WAIT_ACK && !eng_ready) begin
              state <= WAIT_DONE;
            end else if (state == WAIT_DONE && eng_ready) begin
              y_out <= eng_y;
              done  <= 1'b1;
              err   <= 1'b0;
              state <= DELIVER;
            end
          end
        end
        DELIVER: begin
          ptr   <= next_ptr;
          grant <= '0;
          state <= IDLE;
        end
        DRAIN: begin
          if (eng_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_arbiter.sv
// Self-checking bench for tanh_arbiter with a behavioural engine and round-robin model.
module tb_tanh_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TMO  = 20;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] x_in;
  logic [NREQ-1:0]   grant;
  logic              done, err, eng_start, eng_ready, busy;
  logic [W-1:0]      y_out, eng_x, eng_y;

  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   overlaps = 0;
  int   m_ptr = 0;

  int   e_run = 8;
  bit   e_hang = 1'b0;
  bit   e_busy;
  int   e_cnt;
  logic [W-1:0] e_x;

  tanh_arbiter #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req       (req),
    .x_in      (x_in),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .y_out     (y_out),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_ready (eng_ready),
    .eng_y     (eng_y),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] yref(input logic [W-1:0] x);
    return x * 8'd3 + 8'h11;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Engine: ready drops when a start is taken, rises with the result e_run cycles later.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      eng_ready <= 1'b1;
      eng_y     <= '0;
      e_busy    <= 1'b0;
      e_cnt     <= 0;
      e_x       <= '0;
    end else if (e_busy) begin
      if (!e_hang && e_cnt >= e_run - 1) begin
        e_busy    <= 1'b0;
        eng_ready <= 1'b1;
        eng_y     <= yref(e_x);
      end else begin
        e_cnt <= e_cnt + 1;
      end
    end else if (eng_start) begin
      e_busy    <= 1'b1;
      eng_ready <= 1'b0;
      e_cnt     <= 0;
      e_x       <= eng_x;
    end
  end

  always @(posedge Clk) begin
    if (Rst_n === 1'b1 && eng_start === 1'b1) begin
      starts <= starts + 1;
      if (e_busy) overlaps <= overlaps + 1;
    end
  end

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (grant == '0 && n < 300);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (done !== 1'b1 && n < 300);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    req   = '0;
    x_in  = '0;
    #12;
    checks++; if (grant !== '0)     begin errors++; $display("FAIL reset_grant got %b exp 0", grant); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (y_out !== '0)     begin errors++; $display("FAIL reset_y got %h exp 0", y_out); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", eng_start); end
    checks++; if (eng_x !== '0)     begin errors++; $display("FAIL reset_engx got %h exp 0", eng_x); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge Clk);
    Rst_n = 1'b1;
    m_ptr = 0;
    @(negedge Clk);
    checks++; if (grant !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got grant %b busy %b exp 0 0", grant, busy);
    end
  endtask

  task automatic test_single();
    int n, s0, w;
    logic [W-1:0] xv;
    e_run = 12;
    xv = 8'h20;
    x_in = $urandom;
    x_in[2*W +: W] = xv;
    s0 = starts;
    req = 4'b0100;
    wait_grant(n);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", grant); end
    checks++; if (eng_x !== xv)      begin errors++; $display("FAIL single_engx got %h exp %h", eng_x, xv); end
    @(negedge Clk);
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", eng_start); end
    wait_done(n);
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL single_done_timeout got %b exp 1", done); end
    checks++; if (y_out !== yref(xv)) begin errors++; $display("FAIL single_y got %h exp %h", y_out, yref(xv)); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL single_err got %b exp 0", err); end
    checks++; if (grant !== 4'b0100)  begin errors++; $display("FAIL single_grant_at_done got %b exp 0100", grant); end
    checks++; if (starts - s0 != 1)   begin errors++; $display("FAIL single_start_count got %0d exp 1", starts - s0); end
    req = '0;
    m_ptr = 3;
    @(negedge Clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", done); end
    // Pointer now sits at 3: with 0,1,3 requesting, 3 must win.
    x_in = {$urandom};
    req = 4'b1011;
    w = pick(req, m_ptr);
    wait_grant(n);
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL ptr_after_single got %b exp %b", grant, onehot(w)); end
    wait_done(n);
    checks++; if (y_out !== yref(x_in[w*W +: W])) begin
      errors++; $display("FAIL ptr_txn_y got %h exp %h", y_out, yref(x_in[w*W +: W]));
    end
    req = '0;
    m_ptr = (w + 1) % NREQ;
  endtask

  task automatic test_all_four();
    int n, s0, w;
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    m_ptr = 0;
    x_in = $urandom;
    s0 = starts;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      e_run = $urandom_range(2, 10);
      w = pick(req, m_ptr);
      wait_grant(n);
      if (t > 0) begin
        checks++; if (n != 2) begin errors++; $display("FAIL b2b_gap t=%0d got %0d exp 2", t, n); end
      end
      checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL rr_grant t=%0d got %b exp %b", t, grant, onehot(w)); end
      checks++; if (eng_x !== x_in[w*W +: W]) begin
        errors++; $display("FAIL rr_engx t=%0d got %h exp %h", t, eng_x, x_in[w*W +: W]);
      end
      wait_done(n);
      checks++; if (done !== 1'b1 || err !== 1'b0 || grant !== onehot(w) || y_out !== yref(x_in[w*W +: W])) begin
        errors++; $display("FAIL rr_done t=%0d got done %b err %b grant %b y %h exp 1 0 %b %h",
                           t, done, err, grant, y_out, onehot(w), yref(x_in[w*W +: W]));
      end
      m_ptr = (w + 1) % NREQ;
    end
    req = '0;
    @(negedge Clk);
    checks++; if (starts - s0 != 5) begin errors++; $display("FAIL rr_start_count got %0d exp 5", starts - s0); end
    checks++; if (overlaps != 0)    begin errors++; $display("FAIL start_overlap got %0d exp 0", overlaps); end
  endtask

  task automatic test_drop();
    int n, w, stray;
    e_run = 12;
    x_in = $urandom;
    req = 4'b0001;
    w = pick(req, m_ptr);
    wait_grant(n);
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL drop_first_grant got %b exp %b", grant, onehot(w)); end
    req = 4'b1011;
    repeat (3) @(negedge Clk);
    req = 4'b1001;
    wait_done(n);
    checks++; if (done !== 1'b1 || grant !== onehot(w)) begin
      errors++; $display("FAIL drop_first_done got done %b grant %b exp 1 %b", done, grant, onehot(w));
    end
    m_ptr = (w + 1) % NREQ;
    req = 4'b1000;
    w = pick(req, m_ptr);
    wait_grant(n);
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL drop_grant got %b exp %b", grant, onehot(w)); end
    wait_done(n);
    checks++; if (y_out !== yref(x_in[w*W +: W])) begin
      errors++; $display("FAIL drop_y got %h exp %h", y_out, yref(x_in[w*W +: W]));
    end
    m_ptr = (w + 1) % NREQ;
    req = '0;
    stray = 0;
    repeat (20) begin
      @(negedge Clk);
      if (grant !== '0 || done !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL drop_stray got %0d exp 0", stray); end
  endtask

  task automatic test_timeout();
    int n, w;
    x_in = $urandom;
    e_hang = 1'b1;
    req = 4'b0100;
    w = pick(req, m_ptr);
    wait_grant(n);
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL tmo_grant got %b exp %b", grant, onehot(w)); end
    @(negedge Clk);
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL tmo_start got %b exp 1", eng_start); end
    wait_done(n);
    checks++; if (n != TMO)     begin errors++; $display("FAIL tmo_latency got %0d exp %0d", n, TMO); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", err); end
    checks++; if (y_out !== '0) begin errors++; $display("FAIL tmo_y got %h exp 0", y_out); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL tmo_grant_clear got %b exp 0", grant); end
    m_ptr = (w + 1) % NREQ;
    req = 4'b0001;
    repeat (6) @(negedge Clk);
    checks++; if (busy !== 1'b1 || grant !== '0) begin
      errors++; $display("FAIL drain_hold got busy %b grant %b exp 1 0", busy, grant);
    end
    e_hang = 1'b0;
    w = pick(req, m_ptr);
    wait_grant(n);
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL post_drain_grant got %b exp %b", grant, onehot(w)); end
    wait_done(n);
    checks++; if (err !== 1'b0 || y_out !== yref(x_in[w*W +: W])) begin
      errors++; $display("FAIL post_drain_done got err %b y %h exp 0 %h", err, y_out, yref(x_in[w*W +: W]));
    end
    m_ptr = (w + 1) % NREQ;
    req = '0;
  endtask

  task automatic test_reset_midrun();
    int n, w;
    e_run = 30;
    x_in = $urandom;
    req = 4'b0100;
    w = pick(req, m_ptr);
    wait_grant(n);
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL mid_grant got %b exp %b", grant, onehot(w)); end
    repeat (6) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (grant !== '0 || done !== 1'b0 || err !== 1'b0 || y_out !== '0 ||
                  eng_start !== 1'b0 || eng_x !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got g %b d %b e %b y %h s %b x %h b %b exp all 0",
                         grant, done, err, y_out, eng_start, eng_x, busy);
    end
    req = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    m_ptr = 0;
    e_run = 5;
    req = 4'b1001;
    w = pick(req, m_ptr);
    wait_grant(n);
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL reset_ptr_grant got %b exp %b", grant, onehot(w)); end
    wait_done(n);
    checks++; if (y_out !== yref(x_in[w*W +: W]) || err !== 1'b0) begin
      errors++; $display("FAIL reset_ptr_done got y %h err %b exp %h 0", y_out, err, yref(x_in[w*W +: W]));
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_drop();
    test_timeout();
    test_reset_midrun();
    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/tanh_arbiter.md
# tanh_arbiter

Round-robin arbiter and sequencer that shares one tanh series engine among NREQ requesters. It accepts per-requester operand requests, launches the engine with the correct Start handshake, and waits for the engine's ready to return. It then hands the result back to the winning requester with a one-cycle done pulse. It sits between the requester ports and the engine's controller/datapath pair, and it owns the engine's Start input and operand bus.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- TMO, 64, watchdog limit in cycles for one engine run
- Clk  in  1  system clock, rising-edge
- Rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- x_in  in  NREQ*W  operands, requester i at bits [i*W +: W]
- grant  out  NREQ  one-hot current owner, 0 when idle
- done  out  1  one-cycle completion pulse for the granted requester
- err  out  1  valid with done; 1 = run timed out
- y_out  out  W  result, valid while done=1, held until next done
- eng_start  out  1  engine Start
- eng_x  out  W  engine operand, registered
- eng_ready  in  1  engine ready (1 only while engine is idle)
- eng_y  in  W  engine result register
- busy  out  1  1 in every state except IDLE

## Operation
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, DELIVER, DRAIN.
- IDLE: if any req bit and eng_ready=1, then pick the winner via round-robin starting at ptr and set grant. Latch eng_x <= x_in[winner], go to LAUNCH. Otherwise stay.
- LAUNCH: eng_start=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: eng_start=0. When eng_ready=0, the engine has left idle; go to WAIT_DONE.
- WAIT_DONE: when eng_ready=1, capture y_out <= eng_y and go to DELIVER.
- DELIVER: done=1, err=0 for one cycle. Set ptr <= winner+1 mod NREQ, clear grant, go to IDLE.
- Watchdog: a counter clears on entering LAUNCH and increments in WAIT_ACK and WAIT_DONE. At count==TMO-1, force done=1, err=1, y_out=0, advance ptr, clear grant, and go to DRAIN.
- DRAIN: wait for eng_ready=1, then go to IDLE. No new grant is issued while in DRAIN.
- Requester contract: hold req and x_in stable from assertion until done is seen with its grant bit. If req drops before grant, no grant is issued. The arbiter ignores req changes of the owner after grant; eng_x is already latched.
- ptr resets to 0, so requester 0 has first priority. The winner is the first asserted req at index ptr, ptr+1, … with wrap-around.

## Timing
- Reset (Rst_n=0, asynchronous) clears the following: state=IDLE, grant=0, done=0, err=0, y_out=0, eng_start=0, eng_x=0, busy=0, ptr=0, watchdog=0. A reset mid-run drops the transaction silently; the engine must be reset by the same Rst_n domain.
- Grant is registered and appears the cycle after req is sampled in IDLE.
- eng_start is high for exactly 1 cycle, the cycle after grant.
- Latency from req high (idle arbiter) to done = 1 (grant) + 1 (LAUNCH) + 1 (ack) + engine run + 1 (capture) + 1 (DELIVER).
- Back-to-back service: the next grant can occur in the cycle after DELIVER, giving a minimum gap of one IDLE cycle between transactions.
- If eng_ready=0 while in IDLE, no grant is issued.
- All outputs are registered except busy, which decodes state.

## Structure
- Shared package tanh_arb_pkg holds: state enum (IDLE=0, LAUNCH, WAIT_ACK, WAIT_DONE, DELIVER, DRAIN), a 3-bit state width constant, and the default TMO.
- Sub-module rr_pick: combinational round-robin picker with inputs req[NREQ] and ptr, and outputs one-hot grant and index. It is instantiated once.
- The watchdog counter width is $clog2(TMO)+1.

## Test plan
- Single requester: req[2]=1, x_in[2]=8'h20, engine model with a 12-cycle run. Required: grant=4'b0100, one eng_start pulse, eng_x=8'h20, done with y_out equal to the model result, err=0, ptr=3.
- All four req high from reset. Required: grants in order 0,1,2,3,0, one done per grant, and no overlap of eng_start.
- Requester 1 drops req before the grant while 3 is requesting. Required: the grant goes to 3 and no done is issued for 1.
- Engine model never restores ready. Required: done=1, err=1, y_out=0 at TMO cycles after LAUNCH, then DRAIN until ready rises, then IDLE.
- Rst_n pulsed low during WAIT_DONE. Required: all outputs 0 asynchronously, ptr=0, and the next request is served normally from requester 0's priority.
